// File: rtl/imem_load_ctrl.sv
// Boot/reload sequencer owning the instruction-memory address/write port.
// Latency: a loader beat in cycle N is written to memory in cycle N+1; RUN read address is combinational.
// Backpressure: ld_ready is high only in LOAD; a low ld_valid stalls the load without writing.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start, len          (re)load request and image length in words, sampled in IDLE/RUN
//   ld_valid/ld_data    loader word stream, accepted while ld_ready is high
//   ld_ready            controller accepts a word this cycle
//   fetch_pc            byte PC from the IF stage, forwarded as the read address in RUN
//   mem_addr/we/wdata   instruction memory port
//   cpu_rst_n           pipeline reset, released only in RUN
//   busy, done, err     status: load in progress, image-complete pulse, rejected-start pulse
//   misalign            RUN only: fetch_pc not word aligned
module imem_load_ctrl #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic [31:0]   fetch_pc,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  logic len_ok;
  logic beat;
  logic last;
  logic unused_fetch_hi;

  // len is one bit wider than the address so that len==DEPTH is representable.
  assign len_ok = (len != '0) && (len <= (AW+1)'(DEPTH));
  assign beat   = (state_q == S_LOAD) && ld_valid;
  assign last   = ({1'b0, cnt_q} == (len_q - (AW+1)'(1)));

  // PC bits above the memory size are dropped: fetches wrap by truncation.
  assign unused_fetch_hi = &{1'b0, fetch_pc[31:AW+2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          if (len_ok) begin
            state_d = S_LOAD;
            len_d   = len;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // start is deliberately ignored here; only the loader stream advances.
        if (beat) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = ld_data;
          if (last) begin
            // cnt parks at len-1 so len==DEPTH never wraps the counter.
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // The write is registered, so the final word lands during DONE.
  assign ld_ready  = (state_q == S_LOAD);
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = (state_q == S_RUN) ? fetch_pc[AW+1:2] : waddr_q;
  assign cpu_rst_n = (state_q == S_RUN);
  assign busy      = (state_q == S_LOAD) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign misalign  = (state_q == S_RUN) && (|fetch_pc[1:0]);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: boot load, stalled load, rejected starts,
// RUN address mapping, reset mid-load, reload from RUN and a full-depth image.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_imem_load_ctrl;

  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;
  logic          misalign;

  int checks;
  int errors;

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .fetch_pc  (fetch_pc),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // One loader cycle: drive valid/data, then check the write port in that cycle.
  task automatic ld_cyc(input string tag, input logic v, input logic [31:0] d,
                        input logic exp_we, input logic [AW-1:0] exp_addr,
                        input logic [31:0] exp_wd);
    next_cyc();
    ld_valid = v;
    ld_data  = d;
    samp();
    chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_we) begin
      chk({tag, "_addr"}, {25'd0, mem_addr}, {25'd0, exp_addr});
      chk({tag, "_wd"}, mem_wdata, exp_wd);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    fetch_pc = '0;
    repeat (2) @(posedge clk);
    samp();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ---- Test 1: reset state, then boot image of 4 back-to-back words ----
    do_reset();
    chk("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_rdy", {31'd0, ld_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_wd", mem_wdata, 32'd0);
    chk("rst_busy", {29'd0, busy, done, err}, 32'd0);

    next_cyc();
    start = 1'b1;
    len   = 8'd4;
    samp();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    next_cyc();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hA000_0000;
    samp();
    chk("t1_rdy", {31'd0, ld_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_we0", {31'd0, mem_we}, 32'd0);
    ld_cyc("t1_w0", 1'b1, 32'hA000_0001, 1'b1, 7'd0, 32'hA000_0000);
    ld_cyc("t1_w1", 1'b1, 32'hA000_0002, 1'b1, 7'd1, 32'hA000_0001);
    ld_cyc("t1_w2", 1'b1, 32'hA000_0003, 1'b1, 7'd2, 32'hA000_0002);
    ld_cyc("t1_w3", 1'b0, 32'h0,         1'b1, 7'd3, 32'hA000_0003);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_done_rdy", {31'd0, ld_ready}, 32'd0);
    chk("t1_done_cpu", {31'd0, cpu_rst_n}, 32'd0);
    next_cyc();
    samp();
    chk("t1_run_cpu", {31'd0, cpu_rst_n}, 32'd1);
    chk("t1_run_done", {31'd0, done}, 32'd0);
    chk("t1_run_we", {31'd0, mem_we}, 32'd0);
    chk("t1_run_busy", {31'd0, busy}, 32'd0);

    // ---- Test 4: RUN address mapping ----
    fetch_pc = 32'h0000_000C;
    #1;
    chk("t4_addr_c", {25'd0, mem_addr}, 32'd3);
    chk("t4_mis_c", {31'd0, misalign}, 32'd0);
    fetch_pc = 32'h0000_0206;
    #1;
    chk("t4_addr_206", {25'd0, mem_addr}, 32'd1);
    chk("t4_mis_206", {31'd0, misalign}, 32'd1);

    // ---- Test 6: reload from RUN with len=2, then invalid start in RUN ----
    next_cyc();
    fetch_pc = '0;
    start    = 1'b1;
    len      = 8'd2;
    samp();
    chk("t6_still_run", {31'd0, cpu_rst_n}, 32'd1);
    next_cyc();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hB000_0000;
    samp();
    chk("t6_held", {31'd0, cpu_rst_n}, 32'd0);
    chk("t6_rdy", {31'd0, ld_ready}, 32'd1);
    chk("t6_addr_hold", {25'd0, mem_addr}, 32'd3);
    ld_cyc("t6_w0", 1'b1, 32'hB000_0001, 1'b1, 7'd0, 32'hB000_0000);
    ld_cyc("t6_w1", 1'b0, 32'h0,         1'b1, 7'd1, 32'hB000_0001);
    chk("t6_done", {31'd0, done}, 32'd1);
    next_cyc();
    samp();
    chk("t6_run", {31'd0, cpu_rst_n}, 32'd1);
    next_cyc();
    start = 1'b1;
    len   = 8'd0;
    samp();
    chk("t6_err_early", {31'd0, err}, 32'd0);
    next_cyc();
    start = 1'b0;
    samp();
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_err_run", {31'd0, cpu_rst_n}, 32'd1);
    next_cyc();
    samp();
    chk("t6_err_clr", {31'd0, err}, 32'd0);

    // ---- Test 5: reset after 2 of 5 words ----
    do_reset();
    next_cyc();
    start = 1'b1;
    len   = 8'd5;
    samp();
    next_cyc();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hC000_0000;
    samp();
    ld_cyc("t5_w0", 1'b1, 32'hC000_0001, 1'b1, 7'd0, 32'hC000_0000);
    next_cyc();
    ld_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t5_rdy", {31'd0, ld_ready}, 32'd0);
    chk("t5_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_we", {31'd0, mem_we}, 32'd0);
    samp();
    rst_n = 1'b1;

    // ---- Test 3: rejected starts in IDLE ----
    next_cyc();
    start = 1'b1;
    len   = 8'd0;
    samp();
    next_cyc();
    start = 1'b0;
    samp();
    chk("t3_err0", {31'd0, err}, 32'd1);
    chk("t3_busy0", {31'd0, busy}, 32'd0);
    chk("t3_we0", {31'd0, mem_we}, 32'd0);
    next_cyc();
    start = 1'b1;
    len   = 8'd129;
    samp();
    chk("t3_err_gap", {31'd0, err}, 32'd0);
    next_cyc();
    start = 1'b0;
    samp();
    chk("t3_err129", {31'd0, err}, 32'd1);
    chk("t3_busy129", {31'd0, busy}, 32'd0);
    chk("t3_rdy129", {31'd0, ld_ready}, 32'd0);
    next_cyc();
    samp();
    chk("t3_err_clr", {31'd0, err}, 32'd0);

    // ---- Test 2: len=3 with a 2-cycle gap after word 1 ----
    next_cyc();
    start = 1'b1;
    len   = 8'd3;
    samp();
    next_cyc();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hD000_0000;
    samp();
    ld_cyc("t2_w0",  1'b1, 32'hD000_0001, 1'b1, 7'd0, 32'hD000_0000);
    ld_cyc("t2_w1",  1'b0, 32'h0,         1'b1, 7'd1, 32'hD000_0001);
    ld_cyc("t2_gap", 1'b0, 32'h0,         1'b0, 7'd0, 32'h0);
    chk("t2_gap_done", {31'd0, done}, 32'd0);
    ld_cyc("t2_w2pre", 1'b1, 32'hD000_0002, 1'b0, 7'd0, 32'h0);
    chk("t2_pre_done", {31'd0, done}, 32'd0);
    ld_cyc("t2_w2", 1'b0, 32'h0, 1'b1, 7'd2, 32'hD000_0002);
    chk("t2_done", {31'd0, done}, 32'd1);
    next_cyc();
    samp();
    chk("t2_done_once", {31'd0, done}, 32'd0);
    chk("t2_run", {31'd0, cpu_rst_n}, 32'd1);

    // ---- Full-depth image: len=DEPTH from RUN ----
    next_cyc();
    start = 1'b1;
    len   = 8'd128;
    samp();
    next_cyc();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'h0;
    samp();
    for (int i = 1; i < DEPTH; i++) begin
      next_cyc();
      ld_data = 32'(i);
      samp();
    end
    chk("full_pre_done", {31'd0, done}, 32'd0);
    ld_cyc("full_last", 1'b0, 32'h0, 1'b1, 7'd127, 32'd127);
    chk("full_done", {31'd0, done}, 32'd1);
    next_cyc();
    samp();
    chk("full_run", {31'd0, cpu_rst_n}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
